fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
- Byte-stream command sequencer sitting between the chip's 8-bit input bus and the adaptive-coefficient FIR datapath.
- Decodes command headers and loads coefficients by pulsing the FIR's coefficient-set input.
- Streams sample bursts with a continuous valid and drains the FIR pipeline.
- Captures aligned results with an output strobe.
- Hides the FIR's post-reset setup window and its state-driven timing from upstream logic.

Parameters:
- X_N_SIZE, 8, sample/coefficient byte width driven to the FIR.
- Y_N_SIZE, 14, FIR result width.
- NBR_OF_TAPS, 3, coefficient bytes per load command.
- SETUP_CYCLES, 4, cycles held off after reset while the FIR initialises its taps.
- FIR_LATENCY, 2, cycles from a fir_tvalid sample cycle to its result on fir_y_n.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  8  command/data byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_data  out  Y_N_SIZE  captured FIR result.
- out_valid  out  1  one-cycle strobe per result.
- busy  out  1  high in any state except IDLE.
- underrun  out  1  sticky; set on stream stall, cleared by reset or NOP.
- fir_x_n  out  X_N_SIZE  sample/coefficient to the FIR.
- fir_tvalid  out  1  FIR stream enable.
- fir_set_coeffs  out  1  FIR coefficient-shift enable.
- fir_y_n  in  Y_N_SIZE  FIR result.

Behaviour:
Reset values:
- State INIT; all outputs 0 except busy=1; internal counters 0.

Header byte, accepted in IDLE only:
- [7:6]=00 NOP: clears underrun.
- [7:6]=01 LOAD: enters COEF.
- [7:6]=10 STREAM: enters STREAM; burst length N = [5:0]+1, giving 1..64.
- [7:6]=11 reserved: treated as NOP but underrun is not cleared.

States:
- INIT: in_ready=0; count SETUP_CYCLES cycles, then IDLE.
- IDLE: in_ready=1; FIR outputs all 0.
- COEF: in_ready=1.
  - Per accepted byte, the same cycle drives fir_set_coeffs=1 and fir_x_n=byte.
  - Cycles without a byte: fir_set_coeffs=0, fir_x_n held.
  - After the NBR_OF_TAPS-th byte, go to IDLE.
- STREAM: fir_tvalid=1 every cycle; in_ready=1.
  - Accepted byte: fir_x_n=byte; remaining count decrements.
  - No byte available: fir_x_n=0, underrun set, count not decremented.
  - When count reaches 0 after the last accepted sample, go to DRAIN.
- DRAIN: fir_tvalid=1, fir_x_n=0, in_ready=0 for FIR_LATENCY cycles, then IDLE, where fir_tvalid drops.

Capture:
- A FIR_LATENCY-deep shift register of "real sample" flags.
- Stall zeros and drain zeros carry flag 0.
- When the flag exits, register out_data=fir_y_n and pulse out_valid=1.
- Exactly N out_valid pulses per STREAM command, the last in the final DRAIN cycle; each pulse is one cycle.

Invariants:
- fir_tvalid and fir_set_coeffs are never high in the same cycle.
- fir_set_coeffs is never high outside COEF.
- A header byte arriving during a burst is consumed as data; no mid-burst command decode.
- Reset mid-operation returns to INIT: SETUP_CYCLES hold-off repeated, capture pipeline flushed, no out_valid after reset.

Width rules:
- in_data is zero-extended or truncated to X_N_SIZE; no sign handling.
- out_data is passed through unmodified.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP/OP_LOAD/OP_STREAM/OP_RSVD;
  - state encodings INIT/IDLE/COEF/STREAM/DRAIN;
  - header field positions.
- One sub-module, fir_capture_align: the FIR_LATENCY flag shift register plus output register. Parameterised by FIR_LATENCY and Y_N_SIZE.
- The FSM and counters live in the top.

Test Plan:
- Reset held 3 cycles, then released → in_ready=0, busy=1 for exactly 4 cycles; then in_ready=1, busy=0.
- LOAD header 0x40, then bytes 0x05,0x03,0x7F back-to-back → fir_set_coeffs high exactly 3 cycles with fir_x_n=05,03,7F; back in IDLE after that; fir_tvalid stays 0.
- STREAM header 0x83 (N=4), samples 1,2,3,4 contiguous → fir_tvalid high 4+2 cycles; exactly 4 out_valid pulses, first 2 cycles after sample 1; out_data equals fir_y_n at each pulse; underrun=0.
- STREAM 0x81 (N=2) with a 2-cycle gap between samples → 2 zero-sample cycles inserted, underrun=1, still exactly 2 out_valid pulses; a following NOP 0x00 clears underrun.
- Reset asserted mid-STREAM (after 2 of 4 samples) → next cycle fir_tvalid=0, out_valid=0 thereafter, 4-cycle INIT repeated, no residual pulses.
- Byte 0x40 sent as sample data inside a STREAM burst → treated as a sample (fir_x_n=0x40), fir_set_coeffs stays 0.

Source files
------------

// File: rtl/fir_seq_ctrl_pkg.sv
// Shared definitions for the FIR command sequencer: opcodes, FSM states and
// header field positions.
package fir_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STREAM = 2'b10,
    OP_RSVD   = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_COEF   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Header byte layout: opcode in the top two bits, burst length minus one below.
  localparam int HDR_OP_HI  = 7;
  localparam int HDR_OP_LO  = 6;
  localparam int HDR_LEN_HI = 5;
  localparam int HDR_LEN_LO = 0;

  function automatic opcode_t hdr_opcode(input logic [7:0] hdr);
    return opcode_t'(hdr[HDR_OP_HI:HDR_OP_LO]);
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Upstream byte bus and result strobe between the host logic and the sequencer.
interface fir_seq_ctrl_if #(
  parameter int Y_N_SIZE = 14
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [Y_N_SIZE-1:0] out_data;
  logic                out_valid;

  // Host side: sends bytes, receives results.
  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fir_capture_align.sv
// Tracks which FIR input cycles carried real samples and strobes out the
// matching FIR results FIR_LATENCY cycles later.
module fir_capture_align #(
  parameter int FIR_LATENCY = 2,
  parameter int Y_N_SIZE    = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_flag,
  input  logic [Y_N_SIZE-1:0] fir_y_n,
  output logic [Y_N_SIZE-1:0] out_data,
  output logic                out_valid
);

  logic [FIR_LATENCY-1:0] flag_reg;
  logic [Y_N_SIZE-1:0]    data_reg;

  // Flag pipeline aligned to the FIR latency; result held once its flag exits.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_reg <= '0;
      data_reg <= '0;
    end else begin
      flag_reg[0] <= sample_flag;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        flag_reg[i] <= flag_reg[i-1];
      end
      if (flag_reg[FIR_LATENCY-1]) begin
        data_reg <= fir_y_n;
      end
    end
  end

  // During the strobe cycle the FIR is presenting the matching result, so it is
  // passed straight through; the register keeps it stable afterwards.
  assign out_valid = flag_reg[FIR_LATENCY-1];
  assign out_data  = out_valid ? fir_y_n : data_reg;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Byte-stream command sequencer for the adaptive-coefficient FIR: decodes
// headers, loads coefficients, streams bursts, drains the pipeline and
// captures aligned results.
module fir_seq_ctrl
  import fir_seq_ctrl_pkg::*;
#(
  parameter int X_N_SIZE     = 8,
  parameter int Y_N_SIZE     = 14,
  parameter int NBR_OF_TAPS  = 3,
  parameter int SETUP_CYCLES = 4,
  parameter int FIR_LATENCY  = 2
) (
  input  logic                clk,
  input  logic                reset,
  fir_seq_ctrl_if.slave       bus,
  output logic                busy,
  output logic                underrun,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  input  logic [Y_N_SIZE-1:0] fir_y_n
);

  // Wide enough for setup count, tap count, burst length (up to 64) and drain.
  localparam int CNT_W = 16;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [X_N_SIZE-1:0] coef_hold_reg, coef_hold_next;
  logic                underrun_reg, underrun_next;

  logic [X_N_SIZE-1:0] in_byte;
  logic                in_ready_c;
  logic                sample_flag;
  opcode_t             hdr_op;

  // Byte to FIR width: zero-extend when wider, truncate when narrower.
  for (genvar gi = 0; gi < X_N_SIZE; gi++) begin : g_ext
    if (gi < 8) begin : g_bit
      assign in_byte[gi] = bus.in_data[gi];
    end else begin : g_zero
      assign in_byte[gi] = 1'b0;
    end
  end

  assign hdr_op = hdr_opcode(bus.in_data);

  // State, counters, held coefficient and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      coef_hold_reg <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      coef_hold_reg <= coef_hold_next;
      underrun_reg  <= underrun_next;
    end
  end

  // Next-state decode and FIR-facing outputs; outputs follow the accepted byte
  // in the same cycle.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    coef_hold_next = coef_hold_reg;
    underrun_next  = underrun_reg;
    in_ready_c     = 1'b0;
    fir_x_n        = '0;
    fir_tvalid     = 1'b0;
    fir_set_coeffs = 1'b0;
    sample_flag    = 1'b0;

    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == CNT_W'(SETUP_CYCLES - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          case (hdr_op)
            OP_NOP: underrun_next = 1'b0;
            OP_LOAD: begin
              state_next     = ST_COEF;
              cnt_next       = '0;
              coef_hold_next = '0;
            end
            OP_STREAM: begin
              state_next = ST_STREAM;
              cnt_next   = CNT_W'(bus.in_data[HDR_LEN_HI:HDR_LEN_LO]) + 1'b1;
            end
            default: ;  // reserved: ignored, underrun left alone
          endcase
        end
      end

      ST_COEF: begin
        in_ready_c = 1'b1;
        fir_x_n    = coef_hold_reg;
        if (bus.in_valid) begin
          fir_set_coeffs = 1'b1;
          fir_x_n        = in_byte;
          coef_hold_next = in_byte;
          if (cnt_reg == CNT_W'(NBR_OF_TAPS - 1)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        in_ready_c = 1'b1;
        fir_tvalid = 1'b1;
        if (bus.in_valid) begin
          fir_x_n     = in_byte;
          sample_flag = 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end else begin
          // Keep the FIR clocking with a zero sample rather than stalling it.
          underrun_next = 1'b1;
        end
      end

      ST_DRAIN: begin
        fir_tvalid = 1'b1;
        if (cnt_reg == CNT_W'(FIR_LATENCY - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign busy         = (state_reg != ST_IDLE);
  assign underrun     = underrun_reg;

  fir_capture_align #(
    .FIR_LATENCY (FIR_LATENCY),
    .Y_N_SIZE    (Y_N_SIZE)
  ) u_capture (
    .clk         (clk),
    .reset       (reset),
    .sample_flag (sample_flag),
    .fir_y_n     (fir_y_n),
    .out_data    (bus.out_data),
    .out_valid   (bus.out_valid)
  );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed table-driven bench for fir_seq_ctrl plus a mid-stream reset sequence.
module tb_fir_seq_ctrl;

  localparam int YW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy, underrun, fir_tvalid, fir_set_coeffs;
  logic [7:0]    fir_x_n;
  logic [YW-1:0] fir_y_n = 14'h0123;
  logic [YW-1:0] last_y = '0;

  int errors = 0;
  int checks = 0;
  int vec_no = 0;

  always #5 clk = ~clk;

  // FIR stand-in: a result bus that changes every cycle so alignment is visible.
  always @(posedge clk) fir_y_n <= fir_y_n + 14'd37;

  fir_seq_ctrl_if #(.Y_N_SIZE(YW)) bus ();

  fir_seq_ctrl #(
    .X_N_SIZE(8), .Y_N_SIZE(YW), .NBR_OF_TAPS(3), .SETUP_CYCLES(4), .FIR_LATENCY(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .busy           (busy),
    .underrun       (underrun),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .fir_y_n        (fir_y_n)
  );

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       rdy, bsy, setc, tv;
    logic [7:0] x;
    logic       ov, un;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic vld, input logic [7:0] d,
                              input logic rdy, input logic bsy, input logic setc,
                              input logic tv, input logic [7:0] x,
                              input logic ov, input logic un);
    vec_t r;
    r.vld = vld; r.d = d; r.rdy = rdy; r.bsy = bsy; r.setc = setc;
    r.tv = tv; r.x = x; r.ov = ov; r.un = un;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", vec_no, name, act, exp);
    end
  endtask

  // Drive one cycle of input, compare mid-cycle, advance past the next edge.
  task automatic apply(input vec_t t);
    logic [YW-1:0] exp_data;
    bus.in_valid = t.vld;
    bus.in_data  = t.d;
    @(negedge clk);
    if (t.ov) last_y = fir_y_n;
    exp_data = last_y;
    $display("vec%0d vld=%0b data=%02h ready=%0b busy=%0b set=%0b tvalid=%0b x=%02h ov=%0b un=%0b out=%0h",
             vec_no, t.vld, t.d, bus.in_ready, busy, fir_set_coeffs, fir_tvalid,
             fir_x_n, bus.out_valid, underrun, bus.out_data);
    chk("in_ready",       32'(bus.in_ready),    32'(t.rdy));
    chk("busy",           32'(busy),            32'(t.bsy));
    chk("fir_set_coeffs", 32'(fir_set_coeffs),  32'(t.setc));
    chk("fir_tvalid",     32'(fir_tvalid),      32'(t.tv));
    chk("fir_x_n",        32'(fir_x_n),         32'(t.x));
    chk("out_valid",      32'(bus.out_valid),   32'(t.ov));
    chk("underrun",       32'(underrun),        32'(t.un));
    chk("out_data",       32'(bus.out_data),    32'(exp_data));
    vec_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Post-reset hold-off: four INIT cycles, then IDLE.
    repeat (4) vt.push_back(mk(0, 8'h00, 0,1,0,0, 8'h00, 0,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // LOAD, three back-to-back coefficients.
    vt.push_back(mk(1, 8'h40, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h05, 1,1,1,0, 8'h05, 0,0));
    vt.push_back(mk(1, 8'h03, 1,1,1,0, 8'h03, 0,0));
    vt.push_back(mk(1, 8'h7F, 1,1,1,0, 8'h7F, 0,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // LOAD with a gap: coefficient held, set pulse low.
    vt.push_back(mk(1, 8'h40, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h11, 1,1,1,0, 8'h11, 0,0));
    vt.push_back(mk(0, 8'h00, 1,1,0,0, 8'h11, 0,0));
    vt.push_back(mk(1, 8'h22, 1,1,1,0, 8'h22, 0,0));
    vt.push_back(mk(1, 8'h33, 1,1,1,0, 8'h33, 0,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // STREAM N=4, contiguous.
    vt.push_back(mk(1, 8'h83, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h01, 1,1,0,1, 8'h01, 0,0));
    vt.push_back(mk(1, 8'h02, 1,1,0,1, 8'h02, 0,0));
    vt.push_back(mk(1, 8'h03, 1,1,0,1, 8'h03, 1,0));
    vt.push_back(mk(1, 8'h04, 1,1,0,1, 8'h04, 1,0));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // STREAM N=2 with a two-cycle gap, then NOP clears underrun.
    vt.push_back(mk(1, 8'h81, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h0A, 1,1,0,1, 8'h0A, 0,0));
    vt.push_back(mk(0, 8'h00, 1,1,0,1, 8'h00, 0,0));
    vt.push_back(mk(0, 8'h00, 1,1,0,1, 8'h00, 1,1));
    vt.push_back(mk(1, 8'h0B, 1,1,0,1, 8'h0B, 0,1));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 0,1));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,1));
    vt.push_back(mk(1, 8'h00, 1,0,0,0, 8'h00, 0,1));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // STREAM N=1 starting with a stall; reserved opcode keeps underrun.
    vt.push_back(mk(1, 8'h80, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(0, 8'h00, 1,1,0,1, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h55, 1,1,0,1, 8'h55, 0,1));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 0,1));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,1));
    vt.push_back(mk(1, 8'hC5, 1,0,0,0, 8'h00, 0,1));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,1));
    vt.push_back(mk(1, 8'h00, 1,0,0,0, 8'h00, 0,1));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // Header-looking bytes inside a burst are plain samples.
    vt.push_back(mk(1, 8'h81, 1,0,0,0, 8'h00, 0,0));
    vt.push_back(mk(1, 8'h40, 1,1,0,1, 8'h40, 0,0));
    vt.push_back(mk(1, 8'hC3, 1,1,0,1, 8'hC3, 0,0));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));
    // Maximum burst, N=64.
    vt.push_back(mk(1, 8'hBF, 1,0,0,0, 8'h00, 0,0));
    for (int i = 0; i < 64; i++) begin
      vt.push_back(mk(1, 8'(i*3+1), 1,1,0,1, 8'(i*3+1), (i >= 2) ? 1'b1 : 1'b0, 0));
    end
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 0,1,0,1, 8'h00, 1,0));
    vt.push_back(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));

    // Reset held for three edges, released just after the third.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vt[i]) apply(vt[i]);

    // Reset in the middle of a burst, after two of four samples.
    apply(mk(1, 8'h83, 1,0,0,0, 8'h00, 0,0));
    apply(mk(1, 8'h01, 1,1,0,1, 8'h01, 0,0));
    apply(mk(1, 8'h02, 1,1,0,1, 8'h02, 0,0));
    reset = 1'b1;
    apply(mk(0, 8'h00, 1,1,0,1, 8'h00, 1,0));
    reset = 1'b0;
    last_y = '0;
    repeat (4) apply(mk(0, 8'h00, 0,1,0,0, 8'h00, 0,0));
    repeat (3) apply(mk(0, 8'h00, 1,0,0,0, 8'h00, 0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
